// File: rtl/seg_display_scanner_if.sv
// Display-side bundle for seg_display_scanner.
//   enable      : 1 = scan, 0 = display dark
//   digits      : one hex nibble per digit, digit 0 in bits [3:0] (rightmost)
//   blink_mask  : per-digit blink enable
//   blank_mask  : per-digit forced dark
//   dp_mask     : per-digit decimal point
//   lz_en       : leading-zero suppression enable
//   seg         : active-low segments, [6:0] = a..g, [7] = dp
//   an          : active-low anodes, one-hot-low
//   frame_start : one-cycle pulse after an input snapshot is taken
// master = the logic feeding the display, slave = the scanner.
interface seg_display_scanner_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    lz_en;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output enable, digits, blink_mask, blank_mask, dp_mask, lz_en,
    input  seg, an, frame_start
  );

  modport slave (
    input  enable, digits, blink_mask, blank_mask, dp_mask, lz_en,
    output seg, an, frame_start
  );
endinterface

// File: rtl/seg_display_scanner.sv
// Multi-digit seven-segment scan driver. Time-multiplexes NUM_DIGITS hex digits onto one
// shared active-low segment bus with per-digit blink, blank, decimal point and optional
// leading-zero suppression. All display inputs are snapshotted once per frame so a frame
// never tears.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   disp_io : display bundle (slave modport), see seg_display_scanner_if
module seg_display_scanner #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 83333,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  seg_display_scanner_if.slave  disp_io
);

  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned ScanW  = $clog2(SCAN_DIV);
  localparam int unsigned BlinkW = $clog2(BLINK_DIV);
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(NUM_DIGITS - 1);
  localparam logic [ScanW-1:0]  ScanMax  = ScanW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [ScanW-1:0]        scan_cnt_q, scan_cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [BlinkW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                    blink_on_q, blink_on_d;
  logic                    load_pending_q, load_pending_d;
  logic                    frame_start_q, frame_start_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_blink_q, snap_blink_d;
  logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    snap_lz_q, snap_lz_d;

  // Values the current digit is rendered from.
  logic [4*NUM_DIGITS-1:0] view_digits;
  logic [NUM_DIGITS-1:0]   view_blink, view_blank, view_dp;
  logic                    view_lz;
  logic [3:0]              dig_arr [NUM_DIGITS];
  logic                    lz_hit;
  logic [7:0]              digit_seg;
  logic                    scan_wrap, load;

  // Blink timebase free-runs regardless of enable.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BlinkW'(1);
    blink_on_d  = blink_on_q;
    if (blink_cnt_q == BlinkMax) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end
  end

  always_comb begin
    // While a load is pending the snapshot is being replaced this cycle, so render from the
    // incoming values; otherwise the first slot after (re)enable would show stale data.
    if (load_pending_q) begin
      view_digits = disp_io.digits;
      view_blink  = disp_io.blink_mask;
      view_blank  = disp_io.blank_mask;
      view_dp     = disp_io.dp_mask;
      view_lz     = disp_io.lz_en;
    end else begin
      view_digits = snap_digits_q;
      view_blink  = snap_blink_q;
      view_blank  = snap_blank_q;
      view_dp     = snap_dp_q;
      view_lz     = snap_lz_q;
    end

    // lz_hit: every digit from the most significant down to idx is zero.
    lz_hit = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      dig_arr[i] = view_digits[4*i +: 4];
      if ((i >= 32'(idx_q)) && (dig_arr[i] != 4'h0)) begin
        lz_hit = 1'b0;
      end
    end

    digit_seg = {~view_dp[idx_q], hex7(dig_arr[idx_q])};
    if (view_blank[idx_q]) begin
      digit_seg = 8'hFF;
    end else if (view_blink[idx_q] && !blink_on_q) begin
      digit_seg = 8'hFF;
    end else if (view_lz && (idx_q != '0) && lz_hit) begin
      digit_seg[6:0] = 7'h7F;
    end
  end

  always_comb begin
    scan_cnt_d     = scan_cnt_q;
    idx_d          = idx_q;
    load_pending_d = load_pending_q;
    frame_start_d  = 1'b0;
    seg_d          = 8'hFF;
    an_d           = '1;
    snap_digits_d  = snap_digits_q;
    snap_blink_d   = snap_blink_q;
    snap_blank_d   = snap_blank_q;
    snap_dp_d      = snap_dp_q;
    snap_lz_d      = snap_lz_q;
    scan_wrap      = (scan_cnt_q == ScanMax);
    load           = 1'b0;

    if (!disp_io.enable) begin
      scan_cnt_d     = '0;
      idx_d          = '0;
      load_pending_d = 1'b1;
    end else begin
      scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + ScanW'(1);
      if (scan_wrap) begin
        idx_d = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
      end
      // Snapshot at the end of the last digit slot, or immediately on (re)enable.
      load = load_pending_q || (scan_wrap && (idx_q == LastIdx));
      if (load) begin
        snap_digits_d  = disp_io.digits;
        snap_blink_d   = disp_io.blink_mask;
        snap_blank_d   = disp_io.blank_mask;
        snap_dp_d      = disp_io.dp_mask;
        snap_lz_d      = disp_io.lz_en;
        load_pending_d = 1'b0;
      end
      frame_start_d = load;
      an_d[idx_q]   = 1'b0;
      seg_d         = digit_seg;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scan_cnt_q     <= '0;
      idx_q          <= '0;
      blink_cnt_q    <= '0;
      blink_on_q     <= 1'b1;
      load_pending_q <= 1'b1;
      frame_start_q  <= 1'b0;
      seg_q          <= 8'hFF;
      an_q           <= '1;
      snap_digits_q  <= '0;
      snap_blink_q   <= '0;
      snap_blank_q   <= '0;
      snap_dp_q      <= '0;
      snap_lz_q      <= 1'b0;
    end else begin
      scan_cnt_q     <= scan_cnt_d;
      idx_q          <= idx_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_on_q     <= blink_on_d;
      load_pending_q <= load_pending_d;
      frame_start_q  <= frame_start_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
      snap_digits_q  <= snap_digits_d;
      snap_blink_q   <= snap_blink_d;
      snap_blank_q   <= snap_blank_d;
      snap_dp_q      <= snap_dp_d;
      snap_lz_q      <= snap_lz_d;
    end
  end

  assign disp_io.seg         = seg_q;
  assign disp_io.an          = an_q;
  assign disp_io.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner (NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=32).
module tb_seg_display_scanner;

  localparam int unsigned N = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;

  seg_display_scanner_if #(.NUM_DIGITS(N)) disp_if ();

  seg_display_scanner #(
    .NUM_DIGITS(N),
    .SCAN_DIV  (4),
    .BLINK_DIV (32)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .disp_io(disp_if)
  );

  always #5 clk_i = ~clk_i;

  // Edges since the last reset release; blink model derives from this.
  int unsigned ncyc;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ncyc <= 0;
    else         ncyc <= ncyc + 1;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         name;
    logic [15:0]   digits;
    logic [3:0]    blink;
    logic [3:0]    blank;
    logic [3:0]    dp;
    logic          lz;
    logic [3:0][7:0] exp;   // expected seg per digit, index = digit
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  function automatic vec_t mk(input string name, input logic [15:0] digits,
                              input logic [3:0] blink, input logic [3:0] blank,
                              input logic [3:0] dp, input logic lz,
                              input logic [31:0] exp);
    vec_t v;
    v.name   = name;
    v.digits = digits;
    v.blink  = blink;
    v.blank  = blank;
    v.dp     = dp;
    v.lz     = lz;
    v.exp    = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(input vec_t v);
    disp_if.digits     = v.digits;
    disp_if.blink_mask = v.blink;
    disp_if.blank_mask = v.blank;
    disp_if.dp_mask    = v.dp;
    disp_if.lz_en      = v.lz;
  endtask

  // One disabled edge then the first enabled edge (E0); returns just after E0.
  task automatic restart();
    disp_if.enable = 1'b0;
    tick();
    check("dis_an", 32'(disp_if.an), 32'hF);
    check("dis_seg", 32'(disp_if.seg), 32'hFF);
    disp_if.enable = 1'b1;
    tick();
    check("start_fs", 32'(disp_if.frame_start), 32'h1);
    check("start_an", 32'(disp_if.an), 32'hE);
  endtask

  function automatic logic [3:0] an_for(input int d);
    logic [3:0] a;
    a = ~(4'b0001 << d);
    return a;
  endfunction

  function automatic bit blink_vis();
    return (((ncyc - 1) / 32) % 2) == 0;
  endfunction

  initial begin
    int d;
    logic [7:0] e;

    vecs[0] = mk("hex1234",   16'h1234, 4'h0, 4'h0, 4'h0,    1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99});
    vecs[1] = mk("lz0050",    16'h0050, 4'h0, 4'h0, 4'h0,    1'b1, {8'hFF, 8'hFF, 8'h92, 8'hC0});
    vecs[2] = mk("lz0050dp",  16'h0050, 4'h0, 4'h0, 4'b0100, 1'b1, {8'hFF, 8'h7F, 8'h92, 8'hC0});
    vecs[3] = mk("blank89AB", 16'h89AB, 4'h0, 4'b1000, 4'h0, 1'b0, {8'hFF, 8'h90, 8'h88, 8'h83});
    vecs[4] = mk("dpCDEF",    16'hCDEF, 4'h0, 4'h0, 4'b0001, 1'b0, {8'hC6, 8'hA1, 8'h86, 8'h0E});
    vecs[5] = mk("lz0000",    16'h0000, 4'h0, 4'h0, 4'h0,    1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0});
    vecs[6] = mk("lz6070",    16'h6070, 4'h0, 4'h0, 4'h0,    1'b1, {8'h82, 8'hC0, 8'hF8, 8'hC0});
    vecs[7] = mk("blankdp",   16'h1111, 4'h0, 4'b0001, 4'b0001, 1'b0, {8'hF9, 8'hF9, 8'hF9, 8'hFF});
    vecs[8] = mk("nolz0050",  16'h0050, 4'h0, 4'h0, 4'h0,    1'b0, {8'hC0, 8'hC0, 8'h92, 8'hC0});

    disp_if.enable = 1'b0;
    set_in(vecs[0]);

    // Reset state, checked before any clock edge.
    #1 rst_ni = 1'b0;
    #1;
    check("rst_seg", 32'(disp_if.seg), 32'hFF);
    check("rst_an", 32'(disp_if.an), 32'hF);
    check("rst_fs", 32'(disp_if.frame_start), 32'h0);
    tick();
    tick();
    rst_ni = 1'b1;

    // Static patterns: one full frame each, sampled mid-slot.
    for (int v = 0; v < NV; v++) begin
      set_in(vecs[v]);
      restart();
      for (int k = 1; k < 16; k++) begin
        tick();
        check({vecs[v].name, "_fs"}, 32'(disp_if.frame_start), 32'(k == 15));
        if (k % 4 == 1) begin
          d = k / 4;
          check({vecs[v].name, "_an"}, 32'(disp_if.an), 32'(an_for(d)));
          check({vecs[v].name, "_seg"}, 32'(disp_if.seg), 32'(vecs[v].exp[d]));
        end
      end
    end

    // Blink on digit 1 across several blink half-periods.
    set_in(vecs[0]);
    disp_if.blink_mask = 4'b0010;
    restart();
    for (int k = 1; k < 80; k++) begin
      tick();
      if (k % 4 == 1) begin
        d = (k / 4) % 4;
        e = vecs[0].exp[d];
        if (d == 1 && !blink_vis()) e = 8'hFF;
        check("blink_an", 32'(disp_if.an), 32'(an_for(d)));
        check("blink_seg", 32'(disp_if.seg), 32'(e));
      end
    end

    // Input change mid-frame must not affect the remaining digits of that frame.
    set_in(vecs[7]);
    disp_if.blank_mask = 4'h0;
    disp_if.dp_mask    = 4'h0;
    restart();
    for (int k = 1; k < 32; k++) begin
      tick();
      if (k == 4) disp_if.digits = 16'h2222;
      if (k % 4 == 1) begin
        check("coh_seg", 32'(disp_if.seg), (k < 16) ? 32'hF9 : 32'hA4);
      end
    end

    // Enable dropped mid-frame for 5 clocks.
    for (int k = 0; k < 6; k++) tick();
    disp_if.enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("off_an", 32'(disp_if.an), 32'hF);
      check("off_seg", 32'(disp_if.seg), 32'hFF);
      check("off_fs", 32'(disp_if.frame_start), 32'h0);
    end
    disp_if.enable = 1'b1;
    tick();
    check("reen_fs", 32'(disp_if.frame_start), 32'h1);
    check("reen_an", 32'(disp_if.an), 32'hE);
    tick();
    check("reen_seg", 32'(disp_if.seg), 32'hA4);

    // Asynchronous reset mid-slot, then blink restarts in the visible phase.
    set_in(vecs[0]);
    disp_if.blink_mask = 4'b0010;
    for (int k = 0; k < 40; k++) tick();
    #3 rst_ni = 1'b0;
    #1;
    check("arst_seg", 32'(disp_if.seg), 32'hFF);
    check("arst_an", 32'(disp_if.an), 32'hF);
    check("arst_fs", 32'(disp_if.frame_start), 32'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("post_fs", 32'(disp_if.frame_start), 32'h1);
    check("post_an", 32'(disp_if.an), 32'hE);
    for (int k = 1; k < 8; k++) begin
      tick();
      if (k == 1) check("post_d0", 32'(disp_if.seg), 32'h99);
      if (k == 5) begin
        check("post_d1_an", 32'(disp_if.an), 32'hD);
        check("post_d1_seg", 32'(disp_if.seg), 32'hB0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
